cond_logic: RTL and testbench

//  Conditional-execution stage that sits directly downstream of the control decoder.
//  It owns the architectural NZCV flag register and evaluates the 4-bit condition field

---
 rtl/cond_logic.sv | 81 ++++++++
 tb/tb_cond_logic.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/cond_logic.sv
// Conditional-execution stage: owns the NZCV flag register and gates decoder write requests by the condition field.
// Executed/squashed instruction counters saturate instead of wrapping.
module cond_logic #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             En,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             CondEx,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] ExecCount,
  output logic [CNT_W-1:0] SquashCount
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [3:0]       flags_q;
  logic [CNT_W-1:0] exec_q;
  logic [CNT_W-1:0] squash_q;
  logic             n, z, c, v;
  logic             commit;

  assign {n, z, c, v} = flags_q;

  // Evaluated against registered flags only, so an instruction never sees its own ALUFlags.
  always_comb begin
    CondEx = 1'b1;
    case (Cond)
      4'b0000: CondEx = z;
      4'b0001: CondEx = ~z;
      4'b0010: CondEx = c;
      4'b0011: CondEx = ~c;
      4'b0100: CondEx = n;
      4'b0101: CondEx = ~n;
      4'b0110: CondEx = v;
      4'b0111: CondEx = ~v;
      4'b1000: CondEx = c & ~z;
      4'b1001: CondEx = ~c | z;
      4'b1010: CondEx = (n == v);
      4'b1011: CondEx = (n != v);
      4'b1100: CondEx = ~z & (n == v);
      4'b1101: CondEx = z | (n != v);
      default: CondEx = 1'b1;
    endcase
  end

  assign commit   = CondEx & En & ~reset;
  assign PCSrc    = PCS  & commit;
  assign RegWrite = RegW & commit;
  assign MemWrite = MemW & commit;

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q  <= 4'b0000;
      exec_q   <= '0;
      squash_q <= '0;
    end else if (En) begin
      if (CondEx) begin
        if (FlagW[1]) flags_q[3:2] <= ALUFlags[3:2];
        if (FlagW[0]) flags_q[1:0] <= ALUFlags[1:0];
        if (exec_q != '1) exec_q <= exec_q + CNT_ONE;
      end else if (squash_q != '1) begin
        squash_q <= squash_q + CNT_ONE;
      end
    end
  end

  assign Flags       = flags_q;
  assign ExecCount   = exec_q;
  assign SquashCount = squash_q;

endmodule

// File: tb/tb_cond_logic.sv
// Directed bench for cond_logic; a narrow counter width makes saturation reachable.
module tb_cond_logic;

  localparam int CW = 4;
  localparam logic [CW-1:0] CMAX = '1;

  logic          clk = 1'b0;
  logic          reset, En, PCS, RegW, MemW;
  logic [3:0]    Cond, ALUFlags;
  logic [1:0]    FlagW;
  logic          PCSrc, RegWrite, MemWrite, CondEx;
  logic [3:0]    Flags;
  logic [CW-1:0] ExecCount, SquashCount;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic pcsrc;
    logic regwrite;
    logic memwrite;
    logic condex;
  } comb_t;

  typedef struct packed {
    logic [3:0]    flags;
    logic [CW-1:0] exec;
    logic [CW-1:0] squash;
  } state_t;

  comb_t  comb_q[$];
  state_t state_q[$];

  logic [3:0]    m_flags  = 4'b0000;
  logic [CW-1:0] m_exec   = '0;
  logic [CW-1:0] m_squash = '0;

  cond_logic #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .En(En), .Cond(Cond), .ALUFlags(ALUFlags),
    .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
    .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
    .Flags(Flags), .ExecCount(ExecCount), .SquashCount(SquashCount)
  );

  always #5 clk = ~clk;

  // Reference condition: base test on Cond[3:1], inverted by Cond[0] (except AL/1111).
  function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] f);
    logic nf, zf, cf, vf, base;
    {nf, zf, cf, vf} = f;
    case (cc[3:1])
      3'd0: base = zf;
      3'd1: base = cf;
      3'd2: base = nf;
      3'd3: base = vf;
      3'd4: base = cf && !zf;
      3'd5: base = nf == vf;
      3'd6: base = !zf && (nf == vf);
      default: base = 1'b1;
    endcase
    return (cc[3:1] == 3'd7) ? 1'b1 : (base ^ cc[0]);
  endfunction

  task automatic step(input string tag, input logic rst, input logic en,
                      input logic [3:0] cc, input logic [3:0] alu, input logic [1:0] fw,
                      input logic pcs, input logic regw, input logic memw);
    comb_t  ce, co;
    state_t se, so;
    logic   cx;
    @(negedge clk);
    reset = rst; En = en; Cond = cc; ALUFlags = alu; FlagW = fw;
    PCS = pcs; RegW = regw; MemW = memw;
    cx = ref_cond(cc, m_flags);
    ce.condex   = cx;
    ce.pcsrc    = pcs  && cx && en && !rst;
    ce.regwrite = regw && cx && en && !rst;
    ce.memwrite = memw && cx && en && !rst;
    comb_q.push_back(ce);
    if (rst) begin
      m_flags = 4'b0000; m_exec = '0; m_squash = '0;
    end else if (en) begin
      if (cx) begin
        if (fw[1]) m_flags[3:2] = alu[3:2];
        if (fw[0]) m_flags[1:0] = alu[1:0];
        if (m_exec != CMAX) m_exec = m_exec + 1'b1;
      end else if (m_squash != CMAX) begin
        m_squash = m_squash + 1'b1;
      end
    end
    se.flags = m_flags; se.exec = m_exec; se.squash = m_squash;
    state_q.push_back(se);

    #1;
    co = {PCSrc, RegWrite, MemWrite, CondEx};
    ce = comb_q.pop_front();
    checks++;
    assert (co === ce) else begin
      errors++;
      $error("FAIL %s comb {PCSrc,RegWrite,MemWrite,CondEx} obs=%b exp=%b", tag, co, ce);
    end

    @(posedge clk); #1;
    so = {Flags, ExecCount, SquashCount};
    se = state_q.pop_front();
    checks++;
    assert (so === se) else begin
      errors++;
      $error("FAIL %s state flags/exec/squash obs=%h/%0d/%0d exp=%h/%0d/%0d",
             tag, so.flags, so.exec, so.squash, se.flags, se.exec, se.squash);
    end
  endtask

  initial begin
    reset = 1'b1; En = 1'b0; Cond = 4'b1110; ALUFlags = 4'b0000; FlagW = 2'b00;
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0;
    repeat (2) @(posedge clk);
    step("rst_idle", 1, 0, 4'b1110, 4'h0, 2'b00, 0, 0, 0);

    // Reset with flags previously 1111 and a live AL instruction requesting every write
    step("set_1111", 0, 1, 4'b1110, 4'hF, 2'b11, 0, 0, 0);
    step("rst_live", 1, 1, 4'b1110, 4'h5, 2'b11, 1, 1, 1);

    step("subs",     0, 1, 4'b1110, 4'b0110, 2'b11, 0, 0, 0);
    step("eq_regw",  0, 1, 4'b0000, 4'b0000, 2'b00, 0, 1, 0);
    step("ne_fail",  0, 1, 4'b0001, 4'b1001, 2'b11, 1, 0, 0);
    // Own ALUFlags would pass EQ here; registered flags (Z=0) must be used instead
    step("set_0011", 0, 1, 4'b1110, 4'b0011, 2'b11, 0, 0, 0);
    step("no_bypass",0, 1, 4'b0000, 4'b0100, 2'b11, 1, 1, 1);
    step("nz_only",  0, 1, 4'b1110, 4'b1100, 2'b10, 0, 0, 0);
    step("fw_none",  0, 1, 4'b1110, 4'b0000, 2'b00, 0, 0, 0);
    step("cv_only",  0, 1, 4'b1110, 4'b0000, 2'b01, 0, 0, 0);
    step("stall",    0, 0, 4'b1110, 4'h0, 2'b11, 1, 1, 1);

    for (int f = 0; f < 16; f++) begin
      step("sweep_set", 0, 1, 4'b1110, 4'(f), 2'b11, 0, 0, 0);
      for (int cc = 0; cc < 16; cc++)
        step("sweep_cond", 0, 0, 4'(cc), 4'h0, 2'b00, 1, 1, 1);
    end

    // Exec counter has saturated during the sweep; one more must hold at max
    step("exec_sat", 0, 1, 4'b1110, 4'h0, 2'b11, 0, 1, 0);
    for (int i = 0; i < 17; i++)
      step("squash_sat", 0, 1, 4'b0000, 4'h0, 2'b11, 0, 0, 1);
    step("rst_end", 1, 0, 4'b1110, 4'h0, 2'b00, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
